// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: operator encoding, fu_data_t bundle,
// and the default requester count.
package alu_arbiter_pkg;

    localparam int XLEN           = 64;
    localparam int TRANS_ID_BITS  = 3;
    localparam int ALU_ARB_NR_REQ = 2;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        EQ,
        NE
    } fu_op_e;

    typedef struct packed {
        fu_op_e                   operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [XLEN-1:0]          imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr,
// wrapping modulo NR_REQ (also for non-power-of-2 counts).
module alu_rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NR_REQ = ALU_ARB_NR_REQ
) (
    input  logic [NR_REQ-1:0]         req,
    input  logic [$clog2(NR_REQ)-1:0] rr,
    output logic [NR_REQ-1:0]         gnt,
    output logic [$clog2(NR_REQ)-1:0] idx,
    output logic                      found
);

    localparam int IDX_W = $clog2(NR_REQ);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            cand = {1'b0, rr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NR_REQ)) begin
                cand = cand - (IDX_W+1)'(NR_REQ);
            end
            for (int j = 0; j < NR_REQ; j++) begin
                if (!found && req[j] && cand == (IDX_W+1)'(j)) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NR_REQ issue ports, one-entry issue register.
// ALU_ARB_STATS_EN adds per-requester grant counters on grant_cnt_o.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NR_REQ = ALU_ARB_NR_REQ
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NR_REQ-1:0]             req_valid_i,
    input  fu_data_t [NR_REQ-1:0]         req_data_i,
    output logic [NR_REQ-1:0]             req_ready_o,
    output fu_data_t                      alu_data_o,
    input  logic [XLEN-1:0]               alu_result_i,
    input  logic                          alu_branch_res_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [$clog2(NR_REQ)-1:0]     resp_req_o,
    output logic [TRANS_ID_BITS-1:0]      resp_trans_id_o,
    output logic [XLEN-1:0]               resp_result_o,
`ifdef ALU_ARB_STATS_EN
    output logic                          resp_branch_res_o,
    output logic [NR_REQ-1:0][STAT_W-1:0] grant_cnt_o
`else
    output logic                          resp_branch_res_o
`endif
);

    localparam int REQ_IDX_W = $clog2(NR_REQ);

    logic                 issue_valid_q;
    fu_data_t             issue_q;
    logic [REQ_IDX_W-1:0] issue_req_q;
    logic [REQ_IDX_W-1:0] rr_q;

    logic [NR_REQ-1:0]    gnt;
    logic [REQ_IDX_W-1:0] gnt_idx;
    logic                 gnt_any;
    logic                 can_accept;
    logic                 accept;

    alu_rr_arbiter #(
        .NR_REQ (NR_REQ)
    ) i_rr (
        .req   (req_valid_i),
        .rr    (rr_q),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .found (gnt_any)
    );

    // A retiring response frees the register in the same cycle
    assign can_accept = ~rst_i & ~flush_i
                      & (~issue_valid_q | resp_ready_i);
    assign accept      = gnt_any & can_accept;
    assign req_ready_o = gnt & {NR_REQ{can_accept}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
            issue_req_q   <= '0;
            rr_q          <= '0;
        end else if (accept) begin
            issue_valid_q <= 1'b1;
            issue_q       <= req_data_i[gnt_idx];
            issue_req_q   <= gnt_idx;
            rr_q          <= (gnt_idx == REQ_IDX_W'(NR_REQ - 1))
                           ? '0 : gnt_idx + 1'b1;
        end else if (flush_i || resp_ready_i) begin
            issue_valid_q <= 1'b0;
        end
    end

    assign alu_data_o        = issue_q;
    assign resp_valid_o      = issue_valid_q & ~flush_i;
    assign resp_req_o        = issue_req_q;
    assign resp_trans_id_o   = issue_q.trans_id;
    assign resp_result_o     = alu_result_i;
    assign resp_branch_res_o = alu_branch_res_i;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_o <= '0;
        end else begin
            for (int r = 0; r < NR_REQ; r++) begin
                if (req_valid_i[r] && req_ready_o[r]) begin
                    grant_cnt_o[r] <= grant_cnt_o[r] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model behind it.
// Stats checks are compiled in only with ALU_ARB_STATS_EN.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NR = ALU_ARB_NR_REQ;
`ifdef ALU_ARB_STATS_EN
    localparam int SW = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     flush;
    logic [NR-1:0]            req_valid;
    fu_data_t [NR-1:0]        req_data;
    logic [NR-1:0]            req_ready;
    fu_data_t                 alu_data;
    logic [XLEN-1:0]          alu_result;
    logic                     alu_branch;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [$clog2(NR)-1:0]    resp_req;
    logic [TRANS_ID_BITS-1:0] resp_tid;
    logic [XLEN-1:0]          resp_result;
    logic                     resp_branch;
`ifdef ALU_ARB_STATS_EN
    logic [NR-1:0][SW-1:0]    grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .NR_REQ (NR)
`ifdef ALU_ARB_STATS_EN
        ,
        .STAT_W (SW)
`endif
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .req_ready_o       (req_ready),
        .alu_data_o        (alu_data),
        .alu_result_i      (alu_result),
        .alu_branch_res_i  (alu_branch),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_req_o        (resp_req),
        .resp_trans_id_o   (resp_tid),
        .resp_result_o     (resp_result),
`ifdef ALU_ARB_STATS_EN
        .resp_branch_res_o (resp_branch),
        .grant_cnt_o       (grant_cnt)
`else
        .resp_branch_res_o (resp_branch)
`endif
    );

    always_comb begin
        alu_result = '0;
        alu_branch = 1'b0;
        case (alu_data.operation)
            ADD: alu_result = alu_data.operand_a + alu_data.operand_b;
            SUB: alu_result = alu_data.operand_a - alu_data.operand_b;
            EQ:  alu_branch = alu_data.operand_a == alu_data.operand_b;
            NE:  alu_branch = alu_data.operand_a != alu_data.operand_b;
            default: ;
        endcase
    end

    function automatic fu_data_t mk(fu_op_e op, logic [XLEN-1:0] a,
                                    logic [XLEN-1:0] b,
                                    logic [TRANS_ID_BITS-1:0] tid);
        fu_data_t d;
        d           = '0;
        d.operation = op;
        d.operand_a = a;
        d.operand_b = b;
        d.trans_id  = tid;
        return d;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        req_valid   = 2'b11;
        resp_ready  = 1'b1;
        req_data[0] = mk(EQ, 3, 3, 0);
        req_data[1] = mk(ADD, 10, 20, 1);

        // reset
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_alu_data", 64'(alu_data != '0), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // round robin 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_gnt", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i > 0) begin
                check("rr_resp_valid", 64'(resp_valid), 1);
                check("rr_resp_req", 64'(resp_req), 64'((i - 1) % 2));
                if ((i - 1) % 2 == 0)
                    check("rr_branch", 64'(resp_branch), 1);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("rr_last_valid", 64'(resp_valid), 1);
        check("rr_last_req", 64'(resp_req), 1);
        check("rr_last_result", resp_result, 30);
        check("rr_last_tid", 64'(resp_tid), 1);
        check("rr_idle_ready", 64'(req_ready), 0);

        // latency: req1 ADD 5+7 tid 3
        @(posedge clk); #1;
        req_data[1] = mk(ADD, 5, 7, 3);
        req_valid   = 2'b10;
        @(negedge clk);
        check("lat_gnt", 64'(req_ready), 2);
        check("lat_empty", 64'(resp_valid), 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("lat_valid", 64'(resp_valid), 1);
        check("lat_result", resp_result, 12);
        check("lat_tid", 64'(resp_tid), 3);
        check("lat_req", 64'(resp_req), 1);

        // backpressure for 3 cycles, then same-cycle accept
        resp_ready  = 1'b0;
        req_valid   = 2'b01;
        req_data[0] = mk(SUB, 9, 4, 5);
        for (int k = 0; k < 3; k++) begin
            #2;
            check("bp_ready", 64'(req_ready), 0);
            check("bp_valid", 64'(resp_valid), 1);
            check("bp_tid", 64'(resp_tid), 3);
            check("bp_result", resp_result, 12);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_accept", 64'(req_ready), 1);
        @(negedge clk);
        check("bp_next_valid", 64'(resp_valid), 1);
        check("bp_next_result", resp_result, 5);
        check("bp_next_tid", 64'(resp_tid), 5);
        check("bp_next_req", 64'(resp_req), 0);

        // flush with response pending and both requesting
        flush     = 1'b1;
        req_valid = 2'b11;
        #1;
        check("fl_resp_valid", 64'(resp_valid), 0);
        check("fl_ready", 64'(req_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("fl_empty", 64'(resp_valid), 0);
        check("fl_rr_hold", 64'(req_ready), 2);
        req_valid = 2'b00;

`ifdef ALU_ARB_STATS_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("cnt_req0", 64'(grant_cnt[0]), 5);
        check("cnt_req1", 64'(grant_cnt[1]), 3);
        req_valid = 2'b01;
        repeat (12) @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("cnt_wrap0", 64'(grant_cnt[0]), 1);
        check("cnt_hold1", 64'(grant_cnt[1]), 3);
`endif

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
